uart_byte_phy: RTL
==================

// Module: uart_byte_phy
// PURPOSE
//  Byte-level UART transceiver (8N1, LSB first) directly below the command/packet controller.
//  RX: synchronises the serial input, deserialises frames, emits one-cycle rx_data_en per good byte.
//  TX: serialises one byte per tx_data_en; tx_start/tx_busy drive the controller's send pacing.
//  RX and TX are fully independent (full duplex).
// PARAMETERS
//  CLK_FREQ_HZ   100_000_000  system clock frequency
//  BAUD          115200       line rate
//  CLKS_PER_BIT  CLK_FREQ_HZ/BAUD (868)  cycles per bit; must be >= 8; override directly in sim
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  synchronous active-low reset
//  uart_rx      in   1  asynchronous serial input, idle high
//  uart_tx      out  1  serial output, idle high
//  rx_data      out  8  last correctly framed byte received
//  rx_data_en   out  1  one-cycle pulse: rx_data is new and valid
//  rx_frame_err out  1  one-cycle pulse: stop bit sampled low, byte discarded
//  tx_data      in   8  byte to send, sampled when tx_data_en=1
//  tx_data_en   in   1  one-cycle send request
//  tx_start     out  1  one-cycle pulse the cycle after an accepted tx_data_en
//  tx_busy      out  1  high while a frame is on the line
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): uart_tx=1, rx_data=0, rx_data_en=0, rx_frame_err=0, tx_start=0,
//   tx_busy=0, sync FFs=1, both FSMs to IDLE, counters=0. Mid-frame reset aborts; no partial pulse.
//  RX path: 2-FF synchroniser on uart_rx, reset value 1; FSM uses synced bit only.
//   IDLE: synced bit falls to 0 -> START, bit counter cleared.
//   START: after CLKS_PER_BIT/2 cycles resample; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse).
//   DATA: sample every CLKS_PER_BIT cycles (mid-bit), shift in LSB first; after bit 7 -> STOP.
//   STOP: sample after CLKS_PER_BIT; 1 -> rx_data<=byte, rx_data_en=1 for one cycle, -> IDLE;
//    0 -> rx_frame_err=1 one cycle, rx_data unchanged, -> BREAK.
//   BREAK: wait for synced bit=1, then IDLE (a held-low line yields exactly one frame_err).
//   rx_data holds its value until the next good byte; rx_data_en never asserts on consecutive cycles.
//   Back-to-back frames: the next start edge is detectable in the cycle after stop-bit sampling.
//  TX path, states IDLE/START/DATA/STOP:
//   Accept: tx_data_en=1 while tx_start=0 and tx_busy=0 -> latch tx_data; cycle k+1 tx_start=1;
//    cycle k+2 tx_busy=1 and uart_tx=0 (start bit). No gap: tx_start|tx_busy is high from k+1
//    through the end of the stop bit.
//   Each bit lasts exactly CLKS_PER_BIT cycles: start(0), d0..d7, stop(1); frame = 10*CLKS_PER_BIT.
//   tx_busy falls on the cycle after the last stop-bit cycle; a new tx_data_en is accepted that
//    same cycle, so stop bit is never shortened.
//   tx_data_en while tx_start|tx_busy: ignored, no state change, byte dropped.
//   tx_data changing after acceptance has no effect on the frame in flight.
//  Counters: baud counters sized clog2(CLKS_PER_BIT), wrap at CLKS_PER_BIT-1; bit index 3 bits.
// TESTING (sim with CLKS_PER_BIT=16)
//  1 Drive uart_rx frame for 0xA5 at 16 clk/bit -> single rx_data_en pulse, rx_data=0xA5,
//    no rx_frame_err.
//  2 Pulse tx_data_en with tx_data=0x3C -> tx_start at k+1, uart_tx=0 at k+2,
//    bits 0,0,1,1,1,1,0,0 LSB first, stop 1, tx_busy low at k+2+160.
//  3 uart_rx low for 6 cycles then high -> no rx_data_en, no rx_frame_err, RX back in IDLE.
//  4 Frame 0x55 with stop bit forced 0, then line held low 100 cycles, then 0x12 frame ->
//    one rx_frame_err, rx_data stays prior value, then rx_data=0x12.
//  5 Controller-style loop: 38 bytes sent back to back, new tx_data_en in the cycle after tx_busy falls;
//    extra tx_data_en mid-frame -> all 38 bytes on the line in order, injected byte dropped,
//    no stop bit shortened.
//  6 Assert rst_n=0 mid-TX and mid-RX frame -> next edge uart_tx=1, tx_busy=0;
//    no rx_data_en for the aborted frame; a following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_byte_phy.sv
// uart_byte_phy: byte-level 8N1 UART transceiver, LSB first, full duplex.
// RX deserialises a synchronised serial input and flags good bytes or framing errors;
// TX serialises one byte per accepted request and reports pacing via tx_start/tx_busy.
module uart_byte_phy #(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic       rx_data_en,
    output logic       rx_frame_err,
    input  logic [7:0] tx_data,
    input  logic       tx_data_en,
    output logic       tx_start,
    output logic       tx_busy
);

    localparam int unsigned     CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    // RX state
    logic            rx_meta_q, rx_sync_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_en_q, rx_en_d;
    logic            rx_err_q, rx_err_d;

    // TX state
    tx_state_e       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_line_q, tx_line_d;
    logic            tx_start_q, tx_start_d;

    // Two-flop synchroniser for the asynchronous serial input; idles high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_en_q    <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_en_q    <= rx_en_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // RX next state: half-bit start qualification, then mid-bit sampling of data and stop
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_en_d    = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_en_d    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_err_d   = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            tx_start_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            tx_start_q <= tx_start_d;
        end
    end

    // TX next state: IDLE with tx_start high is the one-cycle hand-off before the start bit
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_start_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_start_q) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b0;
                end else if (tx_data_en) begin
                    tx_shift_d = tx_data;
                    tx_start_d = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign uart_tx      = tx_line_q;
    assign tx_start     = tx_start_q;
    assign tx_busy      = (tx_state_q != TX_IDLE);
    assign rx_data      = rx_data_q;
    assign rx_data_en   = rx_en_q;
    assign rx_frame_err = rx_err_q;

endmodule
